// File: rtl/lr_result_reader_pkg.sv
// Shared constants, FSM state and stream kind codes for the XtX/XtY result reader.
package lr_result_reader_pkg;

   localparam int unsigned LR_DIM     = 11;
   localparam int unsigned LR_DATA_W  = 32;
   localparam int unsigned LR_XTX_AW  = 7;
   localparam int unsigned LR_XTY_AW  = 4;
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned XTX_WORDS  = LR_DIM * LR_DIM;
   localparam int unsigned XTY_WORDS  = LR_DIM;
   localparam int unsigned DATA_WORDS = XTX_WORDS + XTY_WORDS;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_WAIT = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      KIND_XTX  = 2'b00,
      KIND_XTY  = 2'b01,
      KIND_CSUM = 2'b10
   } kind_t;

endpackage

// File: rtl/lr_result_reader_if.sv
// Valid/ready word stream carrying dumped result words and their kind tags.
interface lr_result_reader_if #(
   parameter int unsigned DATA_W = 32
);
   import lr_result_reader_pkg::*;

   logic [DATA_W-1:0] m_data;
   kind_t             m_kind;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (output m_data, output m_kind, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_kind, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/lr_result_reader.sv
// Streams XtX then XtY result BRAM contents out on a valid/ready port after start.
// Optional trailing XOR checksum word when LR_READER_CHECKSUM_EN is defined.
module lr_result_reader
   import lr_result_reader_pkg::*;
#(
   parameter int unsigned DIM    = LR_DIM,
   parameter int unsigned DATA_W = LR_DATA_W,
   parameter int unsigned XTX_AW = LR_XTX_AW,
   parameter int unsigned XTY_AW = LR_XTY_AW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [XTX_AW-1:0]    xtx_addr,
   input  logic [DATA_W-1:0]    xtx_dout,
   output logic [XTY_AW-1:0]    xty_addr,
   input  logic [DATA_W-1:0]    xty_dout,
   output logic                 busy,
   output logic                 done,
   lr_result_reader_if.master   m
);

   localparam int unsigned     XTX_N     = DIM * DIM;
   localparam int unsigned     TOTAL_N   = XTX_N + DIM;
   localparam logic [CNT_W-1:0] XTX_N_C  = CNT_W'(XTX_N);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_N - 1);
`ifdef LR_READER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   state_t              state_q, state_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n, cnt_inc;
   logic [XTX_AW-1:0]   xtx_addr_n;
   logic [XTY_AW-1:0]   xty_addr_n;
   logic [DATA_W-1:0]   data_q, data_n;
   kind_t               kind_q, kind_n;
   logic                valid_q, valid_n;
   logic                last_q, last_n;
   logic                busy_n, done_n;
`ifdef LR_READER_CHECKSUM_EN
   logic [DATA_W-1:0]   csum_q, csum_n;
`endif

   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign m.m_data  = data_q;
   assign m.m_kind  = kind_q;
   assign m.m_valid = valid_q;
   assign m.m_last  = last_q;

   // Next-state and next-output logic
   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q;
      xtx_addr_n = xtx_addr;
      xty_addr_n = xty_addr;
      data_n     = data_q;
      kind_n     = kind_q;
      valid_n    = valid_q;
      last_n     = last_q;
      busy_n     = busy;
      done_n     = 1'b0;
`ifdef LR_READER_CHECKSUM_EN
      csum_n     = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_n    = RD_ADDR;
               busy_n     = 1'b1;
               cnt_n      = '0;
               xtx_addr_n = '0;
               xty_addr_n = '0;
               last_n     = 1'b0;
`ifdef LR_READER_CHECKSUM_EN
               csum_n     = '0;
`endif
            end
         end
         RD_ADDR: state_n = RD_WAIT;
         RD_WAIT: begin
            if (cnt_q < XTX_N_C) begin
               data_n = xtx_dout;
               kind_n = KIND_XTX;
            end else begin
               data_n = xty_dout;
               kind_n = KIND_XTY;
            end
            last_n  = !CSUM_EN && (cnt_q == LAST_IDX);
            valid_n = 1'b1;
            state_n = SEND;
         end
         SEND: begin
            if (m.m_ready) begin
               cnt_n = cnt_inc;
               if (last_q) begin
                  valid_n = 1'b0;
                  done_n  = 1'b1;
                  state_n = DONE;
`ifdef LR_READER_CHECKSUM_EN
               end else if (cnt_q == LAST_IDX) begin
                  // Checksum word follows directly, no BRAM access needed
                  data_n = csum_q ^ data_q;
                  kind_n = KIND_CSUM;
                  last_n = 1'b1;
`endif
               end else begin
                  valid_n = 1'b0;
                  state_n = RD_ADDR;
`ifdef LR_READER_CHECKSUM_EN
                  csum_n  = csum_q ^ data_q;
`endif
                  if (cnt_inc < XTX_N_C) xtx_addr_n = XTX_AW'(cnt_inc);
                  else                   xty_addr_n = XTY_AW'(cnt_inc - XTX_N_C);
               end
            end
         end
         DONE: begin
            busy_n  = 1'b0;
            last_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         xtx_addr <= '0;
         xty_addr <= '0;
         data_q   <= '0;
         kind_q   <= KIND_XTX;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef LR_READER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         xtx_addr <= xtx_addr_n;
         xty_addr <= xty_addr_n;
         data_q   <= data_n;
         kind_q   <= kind_n;
         valid_q  <= valid_n;
         last_q   <= last_n;
         busy     <= busy_n;
         done     <= done_n;
`ifdef LR_READER_CHECKSUM_EN
         csum_q   <= csum_n;
`endif
      end
   end

endmodule

// File: tb/tb_lr_result_reader.sv
// Self-checking bench for lr_result_reader: BRAM models, word-queue reference, directed steps.
module tb_lr_result_reader;
   import lr_result_reader_pkg::*;

`ifdef LR_READER_CHECKSUM_EN
   localparam int unsigned TOTAL = DATA_WORDS + 1;
`else
   localparam int unsigned TOTAL = DATA_WORDS;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  kind;
      logic        last;
   } word_t;

   logic        clk, reset, start, busy, done;
   logic [6:0]  xtx_addr;
   logic [3:0]  xty_addr;
   logic [31:0] xtx_dout, xty_dout;
   logic [31:0] xtx_mem [128];
   logic [31:0] xty_mem [16];

   lr_result_reader_if #(.DATA_W(32)) m_if ();

   lr_result_reader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .xtx_addr (xtx_addr),
      .xtx_dout (xtx_dout),
      .xty_addr (xty_addr),
      .xty_dout (xty_dout),
      .busy     (busy),
      .done     (done),
      .m        (m_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      xtx_dout <= xtx_mem[xtx_addr];
      xty_dout <= xty_mem[xty_addr];
   end

   int          n_tests, n_fail, hs_cnt, done_cnt;
   word_t       exp_q[$];
   logic [31:0] got_data [TOTAL];
   logic [1:0]  got_kind [TOTAL];
   logic        got_last [TOTAL];
   bit          pend;
   word_t       pend_w;
   logic [10:0] pend_addr;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
      end
   endtask

   // Expected stream: every XtX word, every XtY word, then optional XOR checksum
   task automatic build_model();
      logic [31:0] x;
      word_t w;
      exp_q.delete();
      x = '0;
      for (int i = 0; i < int'(XTX_WORDS); i++) begin
         w.data = xtx_mem[i]; w.kind = 2'b00; w.last = 1'b0;
         exp_q.push_back(w);
         x ^= xtx_mem[i];
      end
      for (int j = 0; j < int'(XTY_WORDS); j++) begin
         w.data = xty_mem[j]; w.kind = 2'b01; w.last = 1'b0;
         exp_q.push_back(w);
         x ^= xty_mem[j];
      end
`ifdef LR_READER_CHECKSUM_EN
      w.data = x; w.kind = 2'b10; w.last = 1'b1;
      exp_q.push_back(w);
`else
      exp_q[exp_q.size()-1].last = 1'b1;
`endif
      hs_cnt   = 0;
      done_cnt = 0;
      pend     = 1'b0;
   endtask

   // Handshake monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         if (pend) begin
            chk("hold_valid", 64'(m_if.m_valid), 64'(1));
            chk("hold_word", 64'({m_if.m_data, m_if.m_kind, m_if.m_last}), 64'(pend_w));
            chk("hold_addr", 64'({xtx_addr, xty_addr}), 64'(pend_addr));
         end
         pend = 1'b0;
         if (m_if.m_valid && m_if.m_ready) begin
            if (exp_q.size() == 0) chk("extra_word_index", 64'(hs_cnt), 64'(TOTAL - 1));
            else chk($sformatf("word%0d", hs_cnt),
                     64'({m_if.m_data, m_if.m_kind, m_if.m_last}), 64'(exp_q.pop_front()));
            if (hs_cnt < int'(TOTAL)) begin
               got_data[hs_cnt] = m_if.m_data;
               got_kind[hs_cnt] = m_if.m_kind;
               got_last[hs_cnt] = m_if.m_last;
            end
            hs_cnt++;
         end else if (m_if.m_valid) begin
            pend      = 1'b1;
            pend_w    = {m_if.m_data, m_if.m_kind, m_if.m_last};
            pend_addr = {xtx_addr, xty_addr};
         end
         if (done) begin
            done_cnt++;
            chk("done_word_count", 64'(hs_cnt), 64'(TOTAL));
            chk("done_busy", 64'(busy), 64'(1));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   // mode 0: ready high; 1: random ready with 50-cycle stall on word 5; 2: ready mostly high plus stray starts
   task automatic run_dump(input int mode, input int budget);
      bit stalled, fin;
      stalled = 1'b0; fin = 1'b0;
      for (int c = 0; c < budget && !fin; c++) begin
         tick();
         start = 1'b0;
         if (done) begin
            if (mode == 2) start = 1'b1;
            fin = 1'b1;
         end else if (mode == 0) begin
            m_if.m_ready = 1'b1;
         end else if (mode == 1) begin
            if (!stalled && hs_cnt == 5 && m_if.m_valid) begin
               m_if.m_ready = 1'b0;
               repeat (50) tick();
               chk("stall_valid", 64'(m_if.m_valid), 64'(1));
               chk("stall_word5", 64'(m_if.m_data), 64'(exp_q[0].data));
               chk("stall_count", 64'(hs_cnt), 64'(5));
               stalled = 1'b1;
            end
            m_if.m_ready = 1'($urandom_range(0, 1));
         end else begin
            m_if.m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) start = 1'b1;
         end
      end
      chk("done_seen", 64'(fin), 64'(1));
      tick();
      start = 1'b0;
   endtask

   task automatic fill_random();
      foreach (xtx_mem[i]) xtx_mem[i] = $urandom;
      foreach (xty_mem[j]) xty_mem[j] = $urandom;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; hs_cnt = 0; done_cnt = 0; pend = 1'b0;
      reset = 1'b1; start = 1'b0; m_if.m_ready = 1'b0;
      foreach (xtx_mem[i]) xtx_mem[i] = 32'(i);
      foreach (xty_mem[j]) xty_mem[j] = 32'h100 + 32'(j);
      repeat (3) tick();
      reset = 1'b0;

      // Idle after reset: everything zero, addresses still
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_outputs", 64'({xtx_addr, xty_addr, m_if.m_data, m_if.m_kind,
                                  m_if.m_valid, m_if.m_last, busy, done}), 64'(0));
      end

      // Counting preload, ready held high
      build_model();
      pulse_start();
      chk("busy_after_start", 64'(busy), 64'(1));
      run_dump(0, 3000);
      repeat (3) tick();
      chk("done_pulses", 64'(done_cnt), 64'(1));
      chk("busy_after_done", 64'(busy), 64'(0));
      chk("w0", 64'(got_data[0]), 64'h0);
      chk("w120", 64'(got_data[120]), 64'h78);
      chk("w121", 64'({got_data[121], got_kind[121]}), 64'({32'h100, 2'b01}));
      chk("w131", 64'(got_data[131]), 64'h10A);
`ifdef LR_READER_CHECKSUM_EN
      chk("w131_last", 64'(got_last[131]), 64'(0));
      chk("w132_kind_last", 64'({got_kind[132], got_last[132]}), 64'({2'b10, 1'b1}));
`else
      chk("w131_last", 64'(got_last[131]), 64'(1));
`endif

      // Random data, random back-pressure, long stall on word 5
      fill_random();
      build_model();
      pulse_start();
      run_dump(1, 6000);
      repeat (3) tick();
      chk("stall_run_words", 64'(hs_cnt), 64'(TOTAL));

      // Reset in the middle of word 60, then a clean restart
      fill_random();
      build_model();
      pulse_start();
      m_if.m_ready = 1'b1;
      for (int c = 0; c < 3000 && hs_cnt < 60; c++) tick();
      chk("reached_word60", 64'(hs_cnt), 64'(60));
      reset = 1'b1;
      tick();
      chk("abort_state", 64'({busy, m_if.m_valid, done, m_if.m_last, xtx_addr, xty_addr}), 64'(0));
      reset = 1'b0;
      repeat (5) tick();
      chk("abort_idle", 64'({busy, m_if.m_valid}), 64'(0));
      build_model();
      pulse_start();
      run_dump(0, 3000);
      chk("restart_first", 64'(got_data[0]), 64'(xtx_mem[0]));

      // Stray start pulses during the dump and on the done cycle
      fill_random();
      build_model();
      pulse_start();
      run_dump(2, 6000);
      repeat (20) tick();
      chk("stray_start_words", 64'(hs_cnt), 64'(TOTAL));
      chk("stray_start_idle", 64'({busy, m_if.m_valid, done}), 64'(0));
      chk("stray_start_done", 64'(done_cnt), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
